// File: rtl/mem_arbiter_fsm.sv
// Shared main-memory port arbiter: sequences I-cache fills, D-cache fills and
// write-through stores, steering returned words into the owning cache arrays.
module mem_arbiter_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_store,
    input  logic [ADDR_W-1:0] d_store_addr,
    input  logic [ADDR_W-1:0] d_store_data,
    input  logic [ADDR_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [ADDR_W-1:0] fill_data,
    output logic              i_data_we,
    output logic              i_tag_we,
    output logic              d_data_we,
    output logic              d_tag_we,
    output logic              store_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL_I = 3'd1;
    localparam logic [2:0] S_FILL_D = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_RESUME = 3'd4;

    localparam logic [ADDR_W-1:0] BASE_MASK  = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W:0]    ISSUE_LAST = (CNT_W + 1)'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  RECV_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);

    logic [2:0]        state_r, state_nxt_s;
    logic [CNT_W:0]    issue_cnt_r, issue_cnt_nxt_s;
    logic [CNT_W-1:0]  recv_cnt_r, recv_cnt_nxt_s;
    logic [ADDR_W-1:0] base_r, base_nxt_s;

    logic              filling_s, issuing_s, storing_s, recv_s, last_s;
    logic [ADDR_W-1:0] issue_off_s, recv_off_s;

    assign filling_s   = (state_r == S_FILL_I) || (state_r == S_FILL_D);
    assign storing_s   = (state_r == S_STORE);
    assign issuing_s   = filling_s && (issue_cnt_r < ISSUE_LAST);
    // Valids are counted, not cycles, so any memory latency >= 1 works.
    assign recv_s      = filling_s && mem_data_valid;
    assign last_s      = recv_s && (recv_cnt_r == RECV_LAST);
    assign issue_off_s = {{(ADDR_W - CNT_W - 1){1'b0}}, issue_cnt_r[CNT_W-1:0], 1'b0};
    assign recv_off_s  = {{(ADDR_W - CNT_W - 1){1'b0}}, recv_cnt_r, 1'b0};

    // Next-state, grant arbitration and counter update
    always_comb begin
        state_nxt_s     = state_r;
        issue_cnt_nxt_s = issue_cnt_r;
        recv_cnt_nxt_s  = recv_cnt_r;
        base_nxt_s      = base_r;
        case (state_r)
            S_IDLE: begin
                issue_cnt_nxt_s = '0;
                recv_cnt_nxt_s  = '0;
                if (i_miss) begin
                    state_nxt_s = S_FILL_I;
                    base_nxt_s  = i_miss_addr & BASE_MASK;
                end else if (d_miss) begin
                    state_nxt_s = S_FILL_D;
                    base_nxt_s  = d_miss_addr & BASE_MASK;
                end else if (d_store) begin
                    state_nxt_s = S_STORE;
                    base_nxt_s  = d_store_addr & BASE_MASK;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FILL_I, S_FILL_D: begin
                if (issuing_s) begin
                    issue_cnt_nxt_s = issue_cnt_r + {{CNT_W{1'b0}}, 1'b1};
                end else begin
                    issue_cnt_nxt_s = issue_cnt_r;
                end
                if (recv_s) begin
                    recv_cnt_nxt_s = recv_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                end else begin
                    recv_cnt_nxt_s = recv_cnt_r;
                end
                if (last_s) begin
                    state_nxt_s = S_RESUME;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_STORE:  state_nxt_s = S_RESUME;
            S_RESUME: state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // State and counter registers; reset abandons any fill in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            issue_cnt_r <= '0;
            recv_cnt_r  <= '0;
            base_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            issue_cnt_r <= issue_cnt_nxt_s;
            recv_cnt_r  <= recv_cnt_nxt_s;
            base_r      <= base_nxt_s;
        end
    end

    // Memory-side and cache-side output decode
    always_comb begin
        mem_en      = issuing_s || storing_s;
        mem_wr      = storing_s;
        store_done  = storing_s;
        busy        = (state_r != S_IDLE);
        if (storing_s) begin
            mem_addr    = d_store_addr;
            mem_data_in = d_store_data;
        end else if (issuing_s) begin
            mem_addr    = base_r | issue_off_s;
            mem_data_in = '0;
        end else begin
            mem_addr    = '0;
            mem_data_in = '0;
        end
        if (recv_s) begin
            fill_addr = base_r | recv_off_s;
            fill_data = mem_data_out;
        end else begin
            fill_addr = '0;
            fill_data = '0;
        end
        i_data_we = recv_s && (state_r == S_FILL_I);
        d_data_we = recv_s && (state_r == S_FILL_D);
        i_tag_we  = last_s && (state_r == S_FILL_I);
        d_tag_we  = last_s && (state_r == S_FILL_D);
    end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Scoreboard bench for mem_arbiter_fsm: a transaction-level model predicts the
// read, fill and store streams; a monitor compares them as the DUT produces them.
module tb_mem_arbiter_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_store, mem_data_valid;
    logic [15:0] i_miss_addr, d_miss_addr, d_store_addr, d_store_data, mem_data_out;
    logic        mem_en, mem_wr, i_data_we, i_tag_we, d_data_we, d_tag_we, store_done, busy;
    logic [15:0] mem_addr, mem_data_in, fill_addr, fill_data;

    typedef struct {
        logic        dside;
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } fill_t;

    fill_t       exp_fill[$];
    logic [15:0] exp_rd[$];
    int          exp_rd_idx[$];
    logic [31:0] exp_st[$];
    logic [15:0] pend_addr[$];
    int          pend_due[$];

    int   checks = 0;
    int   errors = 0;
    int   lat    = 4;
    int   cyc    = 0;
    logic spurious    = 1'b0;
    logic resume_flag = 1'b0;

    mem_arbiter_fsm dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_store(d_store), .d_store_addr(d_store_addr), .d_store_data(d_store_data),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .i_data_we(i_data_we), .i_tag_we(i_tag_we),
        .d_data_we(d_data_we), .d_tag_we(d_tag_we),
        .store_done(store_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a fill is 8 reads and 8 writes of the aligned block, tag on the last
    task automatic push_fill(input logic dside, input logic [15:0] a);
        logic [15:0] base, wa;
        fill_t       e;
        base = a & 16'hFFF0;
        for (int w = 0; w < 8; w++) begin
            wa = base + 16'(2 * w);
            exp_rd.push_back(wa);
            exp_rd_idx.push_back(w);
            e.dside = dside;
            e.addr  = wa;
            e.data  = mem_val(wa);
            e.tag   = (w == 7);
            exp_fill.push_back(e);
        end
    endtask

    // Memory: pipelined reads returned after lat cycles, plus stray valids when idle
    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = 16'h0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_data_valid = 1'b0;
            mem_data_out   = 16'h0;
            spurious       = 1'b0;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                    mem_data_valid = 1'b1;
                    mem_data_out   = mem_val(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else if ((!busy || resume_flag) && pend_due.size() == 0 &&
                             $urandom_range(0, 2) == 0) begin
                    mem_data_valid = 1'b1;
                    mem_data_out   = 16'($urandom);
                    spurious       = 1'b1;
                end
                if (mem_en && !mem_wr) begin
                    pend_addr.push_back(mem_addr);
                    pend_due.push_back(cyc + lat);
                end
            end
            #1;
            resume_flag = i_tag_we | d_tag_we | store_done;
        end
    end

    // Monitor: pops expected items whenever the DUT presents a read, fill or store
    initial begin
        logic  rd_prev;
        int    post;
        fill_t e;
        logic [15:0] ea;
        logic [31:0] es;
        int    idx;
        rd_prev = 1'b0;
        post    = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rd_prev = 1'b0;
                post    = 0;
                continue;
            end
            chk("we_exclusive", 16'({i_data_we & d_data_we, i_tag_we & d_tag_we}), 16'h0);
            if (spurious) chk("spurious_we", 16'({i_data_we, d_data_we, i_tag_we, d_tag_we}), 16'h0);
            if (i_data_we || d_data_we) begin
                if (exp_fill.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fill_unexpected got addr=%h expected no write at %0t", fill_addr, $time);
                end else begin
                    e = exp_fill.pop_front();
                    chk("fill_owner", 16'({i_data_we, d_data_we}), e.dside ? 16'h1 : 16'h2);
                    chk("fill_addr", fill_addr, e.addr);
                    chk("fill_data", fill_data, e.data);
                    chk("tag_we", 16'({i_tag_we, d_tag_we}),
                        e.tag ? (e.dside ? 16'h1 : 16'h2) : 16'h0);
                end
            end else begin
                chk("fill_addr_quiet", fill_addr, 16'h0);
                chk("fill_data_quiet", fill_data, 16'h0);
                chk("tag_quiet", 16'({i_tag_we, d_tag_we}), 16'h0);
            end
            if (mem_en && !mem_wr) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL read_unexpected got addr=%h expected no read at %0t", mem_addr, $time);
                end else begin
                    ea  = exp_rd.pop_front();
                    idx = exp_rd_idx.pop_front();
                    chk("read_addr", mem_addr, ea);
                    if (idx != 0) chk("read_gap", 16'(rd_prev), 16'h1);
                end
            end
            if (mem_wr || store_done) begin
                if (exp_st.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL store_unexpected got addr=%h expected no store at %0t", mem_addr, $time);
                end else begin
                    es = exp_st.pop_front();
                    chk("store_ctl", 16'({mem_en, mem_wr, store_done}), 16'h7);
                    chk("store_addr", mem_addr, es[31:16]);
                    chk("store_data", mem_data_in, es[15:0]);
                end
            end else begin
                chk("wdata_quiet", mem_data_in, 16'h0);
            end
            if (!busy) chk("idle_quiet", 16'({mem_en, store_done, i_data_we, d_data_we}), 16'h0);
            if (post == 1) chk("resume_busy", 16'({busy, mem_en}), 16'h2);
            if (post == 2) chk("after_resume_idle", 16'(busy), 16'h0);
            if (i_tag_we || d_tag_we || store_done) post = 1;
            else if (post == 1) post = 2;
            else post = 0;
            rd_prev = mem_en && !mem_wr;
        end
    end

    // Cache side: hold requests until served, dropping either at once or during RESUME
    task automatic wait_done(input logic early);
        int   n;
        logic di, dd, ds;
        n = 0; di = 1'b0; dd = 1'b0; ds = 1'b0;
        do begin
            @(negedge clk);
            #2;
            n++;
            if (di) i_miss = 1'b0;
            if (dd) d_miss = 1'b0;
            if (ds) d_store = 1'b0;
            di = 1'b0; dd = 1'b0; ds = 1'b0;
            if (early && i_miss && mem_en && !mem_wr) i_miss = 1'b0;
            if (i_tag_we)   begin if ($urandom_range(0, 1) == 1) i_miss  = 1'b0; else di = 1'b1; end
            if (d_tag_we)   begin if ($urandom_range(0, 1) == 1) d_miss  = 1'b0; else dd = 1'b1; end
            if (store_done) begin if ($urandom_range(0, 1) == 1) d_store = 1'b0; else ds = 1'b1; end
        end while ((i_miss || d_miss || d_store || busy || di || dd || ds) && n < 600);
        if (n >= 600) begin
            checks++; errors++;
            $display("FAIL timeout got busy=%b expected completion within 600 cycles", busy);
            i_miss = 1'b0; d_miss = 1'b0; d_store = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            #3;
            exp_fill.delete(); exp_rd.delete(); exp_rd_idx.delete(); exp_st.delete();
            rst = 1'b0;
        end
        chk("rd_queue_empty", 16'(exp_rd.size()), 16'h0);
        chk("fill_queue_empty", 16'(exp_fill.size()), 16'h0);
        chk("store_queue_empty", 16'(exp_st.size()), 16'h0);
    endtask

    task automatic run_scen(input logic ri, input logic rd, input logic rs,
                            input logic [15:0] ia, input logic [15:0] da,
                            input logic [15:0] sa, input logic [15:0] sd,
                            input int l, input logic early);
        lat = l;
        if (ri) push_fill(1'b0, ia);
        if (rd) push_fill(1'b1, da);
        if (rs) exp_st.push_back({sa, sd});
        @(negedge clk);
        #2;
        i_miss_addr = ia; d_miss_addr = da; d_store_addr = sa; d_store_data = sd;
        i_miss = ri; d_miss = rd; d_store = rs;
        wait_done(early);
    endtask

    initial begin
        int nd;
        logic ri, rd, rs;
        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_store = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_store_addr = 16'h0; d_store_data = 16'h0;
        @(negedge clk);
        #2;
        chk("reset_ctl", 16'({mem_en, mem_wr, store_done, busy, i_data_we, i_tag_we, d_data_we, d_tag_we}), 16'h0);
        chk("reset_mem_addr", mem_addr, 16'h0);
        chk("reset_fill_addr", fill_addr, 16'h0);
        @(negedge clk);
        #3;
        rst = 1'b0;

        run_scen(1'b1, 1'b0, 1'b0, 16'h1236, 16'h0, 16'h0, 16'h0, 4, 1'b0);
        run_scen(1'b1, 1'b1, 1'b0, 16'h0040, 16'h8008, 16'h0, 16'h0, 4, 1'b0);
        run_scen(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'hA002, 16'h5A5A, 4, 1'b0);
        run_scen(1'b0, 1'b1, 1'b1, 16'h0, 16'h4C4E, 16'h4C44, 16'hBEEF, 3, 1'b0);
        run_scen(1'b0, 1'b1, 1'b0, 16'h0, 16'h7A1C, 16'h0, 16'h0, 1, 1'b0);
        run_scen(1'b0, 1'b1, 1'b0, 16'h0, 16'h7A1C, 16'h0, 16'h0, 7, 1'b0);
        run_scen(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0, 16'h0, 16'h0, 2, 1'b1);

        for (int k = 0; k < 25; k++) begin
            ri = 1'($urandom); rd = 1'($urandom); rs = 1'($urandom);
            if (!(ri || rd || rs)) rs = 1'b1;
            run_scen(ri, rd, rs, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     int'($urandom_range(1, 7)), ri & 1'($urandom));
        end

        // Reset in the middle of a D fill after three words have landed
        lat = 3;
        push_fill(1'b1, 16'h3456);
        @(negedge clk);
        #2;
        d_miss_addr = 16'h3456;
        d_miss = 1'b1;
        nd = 0;
        for (int n = 0; n < 100 && nd < 3; n++) begin
            @(negedge clk);
            #2;
            if (d_data_we) nd++;
        end
        chk("pre_reset_words", 16'(nd), 16'h3);
        rst = 1'b1;
        #1;
        chk("async_reset_ctl", 16'({mem_en, busy, d_data_we, d_tag_we, store_done}), 16'h0);
        chk("async_reset_fill", fill_data | fill_addr | mem_addr, 16'h0);
        @(negedge clk);
        #3;
        exp_fill.delete(); exp_rd.delete(); exp_rd_idx.delete(); exp_st.delete();
        push_fill(1'b1, 16'h3456);
        rst = 1'b0;
        wait_done(1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_fsm.md
Name: mem_arbiter_fsm

Overview:
Sequences the single shared main-memory port between three requesters: I-cache miss fill, D-cache miss fill, and D-cache write-through store. It grants one request at a time and issues the 8 pipelined word reads for a block fill. It steers returning words into the owning cache's data array and writes that cache's tag on the last word. It sits between both caches and the 4-cycle pipelined memory, and its busy output drives the pipeline stall.

Parameters:
WORDS_PER_BLOCK, 8, words per cache block (16-byte block, word offset = addr[3:1])
ADDR_W, 16, address and data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_miss  in  1  I-cache miss, held until the fill completes
i_miss_addr  in  16  PC that missed
d_miss  in  1  D-cache miss, held until the fill completes
d_miss_addr  in  16  data address that missed
d_store  in  1  write-through store request, held until store_done
d_store_addr  in  16  store address
d_store_data  in  16  store data
mem_data_out  in  16  read data from memory
mem_data_valid  in  1  mem_data_out valid this cycle
mem_en  out  1  memory access enable
mem_wr  out  1  memory write enable
mem_addr  out  16  memory address
mem_data_in  out  16  memory write data
fill_addr  out  16  cache word address being filled
fill_data  out  16  word to write into the data array
i_data_we  out  1  I-cache data-array write enable
i_tag_we  out  1  I-cache tag-array write enable
d_data_we  out  1  D-cache data-array write enable
d_tag_we  out  1  D-cache tag-array write enable
store_done  out  1  one-cycle pulse when the store is issued
busy  out  1  arbiter not idle; stalls the pipeline

Behaviour:
- States: IDLE, FILL_I, FILL_D, STORE, RESUME. busy = (state != IDLE).
- Reset (async, any state): state=IDLE, issue_cnt=0, recv_cnt=0, base=0. All outputs 0. An in-flight fill is abandoned with no tag write.
- IDLE arbitration, fixed priority: i_miss > d_miss > d_store.
  - On grant, register base = addr & 16'hFFF0.
  - Zero counters.
  - Next state is FILL_I, FILL_D or STORE.
- Grant takes effect the cycle after the request is seen; no memory access occurs in IDLE.
- Fill issue phase (FILL_I/FILL_D), while issue_cnt < 8:
  - mem_en=1, mem_wr=0, mem_addr = base | {issue_cnt,1'b0}.
  - issue_cnt increments every cycle, so there is one read per cycle with no gaps.
  - issue_cnt saturates at 8.
- Fill receive, independent of issue, on each mem_data_valid:
  - fill_data = mem_data_out.
  - fill_addr = base | {recv_cnt,1'b0}.
  - The owning cache's data_we is asserted that cycle and recv_cnt increments.
  - On the valid with recv_cnt==7, the owning tag_we is also asserted and the next state is RESUME.
- The arbiter tolerates any memory latency of 1 cycle or more. It counts valids and does not count cycles.
- STORE, exactly one cycle:
  - mem_en=1, mem_wr=1, mem_addr=d_store_addr, mem_data_in=d_store_data, store_done=1.
  - Next state is RESUME.
- RESUME, one cycle: all requests ignored, outputs idle, next state IDLE. This gives the cache one cycle to drop its miss or store signal after the tag write or store_done.
- mem_data_in=0 whenever mem_wr=0. fill_addr and fill_data are 0 when no data_we is asserted.
- Boundary cases:
  - mem_data_valid in IDLE, STORE or RESUME: ignored, no write enables.
  - Requests arriving during a busy state: not sampled; they are re-arbitrated in IDLE after RESUME.
  - Simultaneous i_miss and d_miss: the I fill runs first, then the D fill (d_miss still held).
  - A store to a missing line arrives as d_miss first, then d_store (write-allocate), and is serviced in that order.
  - A request that drops during a fill does not abort the fill.
- Only one data_we and one tag_we are ever high at a time.

Test Plan:
1. Reset asserted mid-FILL_D after 3 valids -> all outputs 0 immediately (async), no d_tag_we, state IDLE; a subsequent d_miss restarts at word 0.
2. i_miss, i_miss_addr=16'h1236, 4-cycle memory -> mem_addr 1230,1232,...,123E on 8 consecutive cycles. i_data_we fires on each of the 8 valids with fill_addr 1230..123E. i_tag_we fires with the 8th valid. busy stays high through RESUME and drops the cycle after.
3. i_miss and d_miss raised the same cycle (I addr 0040, D addr 8008) -> full I fill of 0040..004E, RESUME, then D fill of 8000..800E. d_data_we is never asserted during the I fill.
4. d_store alone, addr 16'hA002, data 16'h5A5A -> one cycle with mem_en=1, mem_wr=1, mem_addr=A002, mem_data_in=5A5A, store_done=1. Then RESUME, then IDLE. No data or tag write enables.
5. d_store and d_miss held together -> D fill completes first, then the store cycle. Spurious mem_data_valid injected in IDLE and RESUME -> no write enables.
6. Memory latency 1 vs 7 cycles -> identical sequences of fill_addr and data values, tag write on the 8th valid in both cases, and no missed or extra words.
